// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: op codes, FSM states and op-class helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MFHI  = 3'd4,
        MFLO  = 3'd5,
        MTHI  = 3'd6,
        MTLO  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL       = 3'd1,
        DIV_SETUP = 3'd2,
        DIV_ITER  = 3'd3,
        DIV_FIX   = 3'd4
    } state_e;

    function automatic logic is_mul_op(input op_e o);
        return (o == MULT) || (o == MULTU);
    endfunction

    function automatic logic is_div_op(input op_e o);
        return (o == DIV) || (o == DIVU);
    endfunction

    function automatic logic is_signed_op(input op_e o);
        return (o == MULT) || (o == DIV);
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned restoring divider retiring DIV_BITS quotient bits per cycle.
// Latency: WIDTH/DIV_BITS cycles from i_start; o_done is a level held until the next start/abort.
// Backpressure: none; i_start is only honoured by the owner when idle, i_abort stops it at once.
// Ports: clk/rst (sync, active-high); i_start loads i_dividend/i_divisor; i_abort discards work;
//        o_quotient/o_remainder valid while o_done is high.
module muldiv_divider #(
    parameter int WIDTH    = 32,
    parameter int DIV_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_done
);

    localparam int STEPS = WIDTH / DIV_BITS;
    localparam int CW    = $clog2(STEPS + 1);

    logic [WIDTH-1:0] r_quo;   // shifts dividend bits out, quotient bits in
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic             r_done;

    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH:0]   w_ext;   // one extra bit: shifted remainder can exceed WIDTH bits

    always_comb begin
        w_quo = r_quo;
        w_rem = r_rem;
        w_ext = '0;
        for (int j = 0; j < DIV_BITS; j++) begin
            w_ext = {w_rem, w_quo[WIDTH-1]};
            w_quo = {w_quo[WIDTH-2:0], 1'b0};
            if (w_ext >= {1'b0, r_dvs}) begin
                w_ext    = w_ext - {1'b0, r_dvs};
                w_quo[0] = 1'b1;
            end
            w_rem = w_ext[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (i_start) begin
            r_quo  <= i_dividend;
            r_rem  <= '0;
            r_dvs  <= i_divisor;
            r_cnt  <= CW'(STEPS);
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_run) begin
            r_quo <= w_quo;
            r_rem <= w_rem;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
    assign o_done      = r_done;

endmodule

// File: rtl/pipeline_muldiv.sv
// HI/LO owner executing mult/multu/div/divu/mfhi/mflo/mthi/mtlo beside the ALU stage.
// Latency: mul writes HI/LO MUL_STAGES-1 edges after acceptance; div WIDTH/DIV_BITS+2 cycles; mf*/mt* one cycle.
// Backpressure: o_stall = op_valid & busy & !flush; the stalled op is held upstream and taken once busy drops.
// Ports: clk/rst (sync, active-high); i_op_valid/i_op/i_rs_val/i_rt_val issue an op; i_flush aborts
//        in-flight work; o_result_valid/o_result carry mfhi/mflo data; o_busy, o_hi, o_lo for forwarding.
module pipeline_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_op_valid,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_rs_val,
    input  logic [WIDTH-1:0] i_rt_val,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_result_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int STEPS = WIDTH / DIV_BITS;
    localparam int NP    = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int CW    = $clog2(STEPS + MUL_STAGES + 1);
    // HI/LO is written at the end of MUL cycle MUL_LAST; with one stage the write lands on acceptance.
    localparam logic [CW-1:0] MUL_LAST = CW'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
    localparam logic [CW-1:0] DIV_LAST = CW'(STEPS - 1);

    state_e             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_result;
    logic               r_result_valid;
    logic               r_busy;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic               r_qneg;
    logic               r_rneg;
    logic [2*WIDTH-1:0] r_mpipe [NP];

    op_e                w_op;
    logic               w_accept;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;
    logic               w_mul_wr;
    logic               w_div_wr;
    logic               w_unit_wr;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div_start;
    logic [WIDTH-1:0]   w_div_q;
    logic [WIDTH-1:0]   w_div_r;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;

    assign w_op     = op_e'(i_op);
    // Every op class stalls while busy so HI/LO reads and writes stay in program order.
    assign o_stall  = i_op_valid & r_busy & ~i_flush;
    assign w_accept = i_op_valid & ~r_busy & ~i_flush;

    // Extending to 2*WIDTH first makes one unsigned multiplier serve both mult and multu.
    assign w_a_ext = is_signed_op(w_op) ? {{WIDTH{i_rs_val[WIDTH-1]}}, i_rs_val} : {{WIDTH{1'b0}}, i_rs_val};
    assign w_b_ext = is_signed_op(w_op) ? {{WIDTH{i_rt_val[WIDTH-1]}}, i_rt_val} : {{WIDTH{1'b0}}, i_rt_val};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk) begin
        r_mpipe[0] <= w_prod;
        for (int i = 1; i < NP; i++) begin
            r_mpipe[i] <= r_mpipe[i-1];
        end
    end

    assign w_mul_res = (MUL_STAGES == 1) ? w_prod : r_mpipe[NP-1];
    // The final write commits even under flush, so neither write qualifier looks at i_flush.
    assign w_mul_wr  = (MUL_STAGES == 1) ? (w_accept & is_mul_op(w_op))
                                         : ((r_state == MUL) && (r_cnt == MUL_LAST));
    assign w_div_wr  = (r_state == DIV_FIX) && w_div_done;
    assign w_unit_wr = w_mul_wr | w_div_wr;

    assign w_a_mag     = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_b_mag     = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
    assign w_div_start = (r_state == DIV_SETUP) && !i_flush;

    muldiv_divider #(
        .WIDTH    (WIDTH),
        .DIV_BITS (DIV_BITS)
    ) u_divider (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .i_abort     (i_flush),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r),
        .o_done      (w_div_done)
    );

    // MIN / -1 needs no special path: |MIN| / 1 negated wraps back to MIN with remainder 0.
    assign w_div_lo = (r_b == '0) ? '1  : (r_qneg ? -w_div_q : w_div_q);
    assign w_div_hi = (r_b == '0) ? r_a : (r_rneg ? -w_div_r : w_div_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_hi           <= '0;
            r_lo           <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_a            <= '0;
            r_b            <= '0;
            r_signed       <= 1'b0;
            r_qneg         <= 1'b0;
            r_rneg         <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            // busy stays up for one cycle after a HI/LO write so consumers see the new value.
            r_busy         <= w_unit_wr;
            r_cnt          <= r_cnt + 1'b1;

            if (w_mul_wr) begin
                {r_hi, r_lo} <= w_mul_res;
            end
            if (w_div_wr) begin
                r_hi <= w_div_hi;
                r_lo <= w_div_lo;
            end

            if (w_accept) begin
                case (w_op)
                    MFHI: begin
                        r_result       <= r_hi;
                        r_result_valid <= 1'b1;
                    end
                    MFLO: begin
                        r_result       <= r_lo;
                        r_result_valid <= 1'b1;
                    end
                    MTHI:    r_hi <= i_rs_val;
                    MTLO:    r_lo <= i_rs_val;
                    default: ;
                endcase
            end

            case (r_state)
                IDLE: begin
                    if (w_accept && is_mul_op(w_op)) begin
                        r_state <= MUL;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_accept && is_div_op(w_op)) begin
                        r_state  <= DIV_SETUP;
                        r_a      <= i_rs_val;
                        r_b      <= i_rt_val;
                        r_signed <= is_signed_op(w_op);
                        r_busy   <= 1'b1;
                    end
                end
                MUL: begin
                    if (i_flush || r_cnt == MUL_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_busy  <= 1'b1;
                    end
                end
                DIV_SETUP: begin
                    if (i_flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= DIV_ITER;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_qneg  <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                        r_rneg  <= r_signed & r_a[WIDTH-1];
                    end
                end
                DIV_ITER: begin
                    if (i_flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_busy <= 1'b1;
                        if (r_cnt == DIV_LAST) begin
                            r_state <= DIV_FIX;
                        end
                    end
                end
                DIV_FIX: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;
    assign o_busy         = r_busy;
    assign o_hi           = r_hi;
    assign o_lo           = r_lo;

endmodule
